// File: rtl/trace_buffer.sv
//==============================================================================
// Module   : trace_buffer
// Brief    : Commit-trace recorder. Captures one retired-instruction record per
//            cycle into a circular buffer drained over valid/ready.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module trace_buffer #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cap_valid,
   input  logic [XLEN-1:0]          cap_pc,
   input  logic [31:0]              cap_instr,
   input  logic [4:0]               cap_rd,
   input  logic [XLEN-1:0]          cap_wdata,
   input  logic                     mode_wrap,
   input  logic                     trig_en,
   input  logic [XLEN-1:0]          trig_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [31:0]              out_instr,
   output logic [4:0]               out_rd,
   output logic [XLEN-1:0]          out_wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic                     triggered
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int REC_W = 2 * XLEN + 37;

   localparam logic [CW-1:0]    C_FULL     = CW'(DEPTH);
   localparam logic [CNT_W-1:0] C_DROP_MAX = '1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             triggered_q, triggered_d;

   logic [REC_W-1:0] mem_q [DEPTH];
   logic             w_mem_we;
   logic [REC_W-1:0] w_rec;
   logic             w_match;
   logic             w_push;
   logic             w_pop;
   logic             w_full;

   // x0 is hardwired to zero, so its writeback value is meaningless
   assign w_rec   = {cap_pc, cap_instr, cap_rd, (cap_rd == 5'd0) ? {XLEN{1'b0}} : cap_wdata};
   assign w_match = cap_valid && (cap_pc == trig_pc);
   assign w_push  = cap_valid && (!trig_en || triggered_q || w_match);
   assign w_pop   = out_valid && out_ready;
   assign w_full  = (count_q == C_FULL);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      drop_cnt_d  = drop_cnt_q;
      triggered_d = triggered_q;
      w_mem_we    = 1'b0;

      if (!trig_en) begin
         triggered_d = 1'b0;
      end else if (w_match) begin
         triggered_d = 1'b1;
      end

      // A pop can only happen when non-empty, so push+pop never needs a drop
      case ({w_push, w_pop})
         2'b11: begin
            w_mem_we = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         2'b10: begin
            if (!w_full) begin
               w_mem_we = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               count_d  = count_q + 1'b1;
            end else begin
               if (drop_cnt_q != C_DROP_MAX) begin
                  drop_cnt_d = drop_cnt_q + 1'b1;
               end
               if (mode_wrap) begin
                  w_mem_we = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         2'b01: begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         drop_cnt_q  <= '0;
         triggered_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         drop_cnt_q  <= drop_cnt_d;
         triggered_q <= triggered_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         mem_q[wr_ptr_q] <= w_rec;
      end
   end

   assign {out_pc, out_instr, out_rd, out_wdata} = mem_q[rd_ptr_q];
   assign out_valid = (count_q != '0);
   assign count     = count_q;
   assign drop_cnt  = drop_cnt_q;
   assign triggered = triggered_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_buffer.sv
//==============================================================================
// Module   : tb_trace_buffer
// Brief    : Directed scoreboard bench for trace_buffer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_trace_buffer;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cap_valid;
   logic [31:0] cap_pc;
   logic [31:0] cap_instr;
   logic [4:0]  cap_rd;
   logic [31:0] cap_wdata;
   logic        mode_wrap;
   logic        trig_en;
   logic [31:0] trig_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [4:0]  out_rd;
   logic [31:0] out_wdata;
   logic [4:0]  count;
   logic [15:0] drop_cnt;
   logic        triggered;

   int   total = 0;
   int   bad   = 0;
   rec_t sb[$];

   trace_buffer #(.XLEN(32), .DEPTH(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
      .cap_rd(cap_rd), .cap_wdata(cap_wdata),
      .mode_wrap(mode_wrap), .trig_en(trig_en), .trig_pc(trig_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_rd(out_rd), .out_wdata(out_wdata),
      .count(count), .drop_cnt(drop_cnt), .triggered(triggered)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic rec_t mk(input logic [31:0] pc);
      rec_t r;
      r.pc    = pc;
      r.instr = pc ^ 32'hA5A5_0013;
      r.rd    = 5'(pc[6:2] + 5'd1);
      r.wdata = pc + 32'h0000_1000;
      return r;
   endfunction

   function automatic rec_t stored(input rec_t r);
      rec_t s = r;
      if (r.rd == 5'd0) s.wdata = 32'h0;
      return s;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input rec_t r, input bit expect_out);
      cap_valid = 1'b1;
      cap_pc    = r.pc;
      cap_instr = r.instr;
      cap_rd    = r.rd;
      cap_wdata = r.wdata;
      if (expect_out) sb.push_back(stored(r));
      step();
      cap_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      out_ready = 1'b1;
      repeat (n) step();
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
   endtask

   // Monitor: every accepted output must match the oldest scoreboard entry
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL out_unexpected: got pc %0h want no output", out_pc);
         end else begin
            rec_t e;
            e = sb.pop_front();
            if ({out_pc, out_instr, out_rd, out_wdata} !== e) begin
               bad++;
               $display("FAIL out_rec: got pc=%0h instr=%0h rd=%0d wdata=%0h want pc=%0h instr=%0h rd=%0d wdata=%0h",
                        out_pc, out_instr, out_rd, out_wdata, e.pc, e.instr, e.rd, e.wdata);
            end
         end
      end
   end

   initial begin
      rec_t r;
      cap_valid = 1'b0; cap_pc = '0; cap_instr = '0; cap_rd = '0; cap_wdata = '0;
      mode_wrap = 1'b0; trig_en = 1'b0; trig_pc = '0; out_ready = 1'b0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_trig", 64'(triggered), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Basic push of three, show-ahead, then in-order drain
      cap_valid = 1'b1; cap_pc = 32'h0;
      #1;
      chk("no_bypass_valid", 64'(out_valid), 64'd0);
      for (int i = 0; i < 3; i++) push(mk(32'(4 * i)), 1'b1);
      chk("s1_count", 64'(count), 64'd3);
      chk("s1_valid", 64'(out_valid), 64'd1);
      chk("s1_head_pc", 64'(out_pc), 64'h0);
      chk("s1_head_rd", 64'(out_rd), 64'd1);
      drain(3);
      chk("s1_empty_valid", 64'(out_valid), 64'd0);
      chk("s1_empty_count", 64'(count), 64'd0);

      // Stop-when-full: newest four dropped
      do_reset();
      mode_wrap = 1'b0;
      for (int i = 0; i < 20; i++) push(mk(32'(4 * i)), i < 16);
      chk("stop_count", 64'(count), 64'd16);
      chk("stop_drop", 64'(drop_cnt), 64'd4);
      drain(16);
      chk("stop_drained", 64'(count), 64'd0);

      // Wrap-when-full: oldest four overwritten
      do_reset();
      mode_wrap = 1'b1;
      for (int i = 0; i < 20; i++) push(mk(32'(4 * i)), i >= 4);
      chk("wrap_count", 64'(count), 64'd16);
      chk("wrap_drop", 64'(drop_cnt), 64'd4);
      chk("wrap_head_pc", 64'(out_pc), 64'h10);
      drain(16);
      chk("wrap_drained", 64'(count), 64'd0);

      // PC trigger at 0x20
      do_reset();
      mode_wrap = 1'b0; trig_en = 1'b1; trig_pc = 32'h20;
      for (int i = 0; i < 16; i++) begin
         push(mk(32'(4 * i)), i >= 8);
         if (i == 7) chk("trig_pre_count", 64'(count), 64'd0);
         if (i == 7) chk("trig_pre_flag", 64'(triggered), 64'd0);
         if (i == 8) chk("trig_flag", 64'(triggered), 64'd1);
      end
      chk("trig_count", 64'(count), 64'd8);
      chk("trig_drop", 64'(drop_cnt), 64'd0);
      chk("trig_head_pc", 64'(out_pc), 64'h20);
      drain(8);
      trig_en = 1'b0;
      step();
      chk("trig_clear", 64'(triggered), 64'd0);

      // Full buffer with simultaneous push and pop in both modes
      do_reset();
      mode_wrap = 1'b0;
      for (int i = 0; i < 16; i++) push(mk(32'(4 * i)), 1'b1);
      out_ready = 1'b1;
      for (int i = 16; i < 26; i++) push(mk(32'(4 * i)), 1'b1);
      chk("pp_stop_count", 64'(count), 64'd16);
      chk("pp_stop_drop", 64'(drop_cnt), 64'd0);
      mode_wrap = 1'b1;
      for (int i = 26; i < 36; i++) push(mk(32'(4 * i)), 1'b1);
      chk("pp_wrap_count", 64'(count), 64'd16);
      chk("pp_wrap_drop", 64'(drop_cnt), 64'd0);
      drain(16);
      chk("pp_drained", 64'(count), 64'd0);

      // x0 destination stores zero writeback data
      mode_wrap = 1'b0;
      r.pc = 32'h100; r.instr = 32'h0000_0013; r.rd = 5'd0; r.wdata = 32'hDEAD_BEEF;
      push(r, 1'b1);
      chk("x0_wdata", 64'(out_wdata), 64'h0);
      drain(1);

      // Asynchronous reset mid-stream with count=5, drop=1, triggered=1
      do_reset();
      trig_en = 1'b1; trig_pc = 32'h0;
      for (int i = 0; i < 17; i++) push(mk(32'(4 * i)), i < 11);
      drain(11);
      chk("pre_rst_count", 64'(count), 64'd5);
      chk("pre_rst_drop", 64'(drop_cnt), 64'd1);
      chk("pre_rst_trig", 64'(triggered), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_drop", 64'(drop_cnt), 64'd0);
      chk("arst_trig", 64'(triggered), 64'd0);
      rst = 1'b0;
      trig_en = 1'b0;
      step();

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
- Hardware commit-trace recorder for the RISC-V core.
- Captures one record per retired instruction: PC, instruction word, destination register and writeback data.
- Stores records in a parametrised circular buffer; a debug/host side drains them through a valid/ready handshake.
- Supports a PC-match trigger, a selectable full policy (stop or wrap) and a saturating drop counter, so the core's register state can be traced in hardware rather than only in simulation.

Parameters:
XLEN, 32, width of PC and writeback data
DEPTH, 16, number of records; power of two, >= 2
CNT_W, 16, width of the saturating drop counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
cap_valid  input  1  a retired-instruction record is presented this cycle
cap_pc  input  XLEN  PC of the retired instruction
cap_instr  input  32  instruction word
cap_rd  input  5  destination register index
cap_wdata  input  XLEN  writeback data
mode_wrap  input  1  0 = stop when full (drop newest); 1 = overwrite oldest
trig_en  input  1  1 = arm the PC trigger; 0 = capture unconditionally
trig_pc  input  XLEN  trigger PC
out_valid  output  1  oldest record available
out_ready  input  1  consumer accepts the record
out_pc  output  XLEN  oldest record PC
out_instr  output  32  oldest record instruction
out_rd  output  5  oldest record rd
out_wdata  output  XLEN  oldest record writeback data
count  output  $clog2(DEPTH)+1  records held, 0..DEPTH
drop_cnt  output  CNT_W  records lost, saturating
triggered  output  1  sticky trigger-hit flag

Behaviour:
- Reset (async, rst=1): wr_ptr, rd_ptr, count, drop_cnt and triggered go to 0, and out_valid goes to 0. Storage is not reset. Reset asserted mid-operation discards all contents immediately.
- Capture qualification: a push is requested when cap_valid=1 and either trig_en=0 or triggered=1, or when cap_valid=1, trig_en=1 and cap_pc==trig_pc.
  - A record whose PC matches the trigger is itself captured.
  - triggered is set at that edge and stays set while trig_en=1.
  - trig_en=0 clears triggered at the next edge.
  - While trig_en=1 and triggered=0, non-matching records are ignored and do not count as drops.
- Stored wdata: when cap_rd==0, the stored wdata is forced to 0, mirroring the x0 hardwire.
- Pop: occurs when out_valid & out_ready.
  - out_valid = (count != 0).
  - out_* present the record at rd_ptr combinationally (show-ahead) and are meaningful only when out_valid=1.
- Latency: a record pushed at edge N is visible on out_* with out_valid=1 in the cycle after edge N. There is no same-cycle bypass: empty plus push gives out_valid=0 in that cycle.
- Pointers: log2(DEPTH) bits each, and wrap naturally modulo DEPTH.
- Push and pop outcomes by buffer state:
  - Not full, push only: write at wr_ptr, wr_ptr+1, count+1.
  - Pop only: rd_ptr+1, count-1.
  - Push and pop, count in 1..DEPTH: both happen, count unchanged, no drop. This holds even when full, in either mode.
  - Push and pop, empty: pop is ignored (out_valid=0), push proceeds.
  - Full, push only, mode_wrap=0: new record discarded, drop_cnt+1.
  - Full, push only, mode_wrap=1: overwrite at wr_ptr, wr_ptr+1, rd_ptr+1, count stays DEPTH, drop_cnt+1 (oldest lost).
- drop_cnt saturates at 2^CNT_W-1 and never wraps.
- mode_wrap and trig_pc may change at any cycle and take effect in the same cycle.

Test Plan:
- Reset, then push 3 records (PC 0x0,0x4,0x8, rd=1,2,3) with out_ready=0. Required: count=3, out_valid=1, out_pc=0x0. Then out_ready=1 for 3 cycles: pops in order 0x0,0x4,0x8, then out_valid=0 and count=0.
- DEPTH=16, mode_wrap=0, push 20 records with PC=4*i, no pops. Required: count=16, drop_cnt=4, and the drained PCs are 0x00..0x3C.
- Same stimulus as the previous scenario with mode_wrap=1. Required: count=16, drop_cnt=4, and the drained PCs are 0x10..0x4C.
- trig_en=1, trig_pc=0x20, stream PCs 0x0..0x3C. Required: the first captured record is 0x20, triggered=1 from the following cycle, count=8 and drop_cnt=0.
- Full buffer with simultaneous push and pop every cycle for 10 cycles, in both modes. Required: count stays 16, drop_cnt unchanged, output order preserved. Separately, a record with cap_rd=0 and cap_wdata=0xDEADBEEF is read back with out_wdata=0.
- Assert rst mid-stream with count=5. Required: out_valid=0, count=0, drop_cnt=0 and triggered=0 immediately, without waiting for a clock edge.
